// File: rtl/static_to_dynamic_7seg_scanner.sv
// static_to_dynamic_7seg_scanner: scans a snapshotted static segment image onto one-hot digit strobes; DYNAMIC_7SEG_BLANK_GAP_EN adds an all-off gap between digits
module static_to_dynamic_7seg_scanner #(
    parameter int w_digit      = 8,
    parameter int w_seg        = 8,
    parameter int dwell_cycles = 4096,
    parameter int blank_cycles = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [w_digit-1:0][w_seg-1:0]  hex,
    output logic [w_seg-1:0]               hgfedcba,
    output logic [w_digit-1:0]             digit,
    output logic                           frame_start
);
    localparam int cw = $clog2((dwell_cycles > blank_cycles ? dwell_cycles : blank_cycles) + 1);
    localparam int iw = w_digit > 1 ? $clog2(w_digit) : 1;
`ifdef DYNAMIC_7SEG_BLANK_GAP_EN
    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHOW} state_t;
`endif
    state_t                        state, state_n;
    logic [iw-1:0]                 idx, idx_n, ni;
    logic [cw-1:0]                 cnt, cnt_n;
    logic [w_digit-1:0][w_seg-1:0] snap, snap_n;
    logic [w_seg-1:0]              seg_n;
    logic [w_digit-1:0]            dig_n;
    logic                          fs_n, wrap;
    assign wrap = idx == iw'(w_digit - 1);
    assign ni   = wrap ? '0 : idx + iw'(1);
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            snap        <= '0;
            hgfedcba    <= '0;
            digit       <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            cnt         <= cnt_n;
            snap        <= snap_n;
            hgfedcba    <= seg_n;
            digit       <= dig_n;
            frame_start <= fs_n;
        end
    end
    // Outputs are computed as next-state values so they appear on the edge that changes state
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        snap_n  = snap;
        seg_n   = hgfedcba;
        dig_n   = digit;
        fs_n    = 1'b0;
        if (!enable) begin
            state_n = IDLE;
            idx_n   = '0;
            cnt_n   = '0;
            seg_n   = '0;
            dig_n   = '0;
        end else if (state == IDLE) begin
            state_n = SHOW;
            idx_n   = '0;
            cnt_n   = '0;
            snap_n  = hex;
            seg_n   = hex[0];
            dig_n   = w_digit'(1);
            fs_n    = 1'b1;
        end else if (state == SHOW && cnt != cw'(dwell_cycles - 1)) begin
            cnt_n = cnt + cw'(1);
`ifdef DYNAMIC_7SEG_BLANK_GAP_EN
        end else if (state == SHOW) begin
            state_n = BLANK;
            cnt_n   = '0;
            seg_n   = '0;
            dig_n   = '0;
        end else if (cnt != cw'(blank_cycles - 1)) begin
            cnt_n = cnt + cw'(1);
`endif
        end else begin
            state_n = SHOW;
            idx_n   = ni;
            cnt_n   = '0;
            snap_n  = wrap ? hex : snap;
            seg_n   = wrap ? hex[0] : snap[ni];
            dig_n   = w_digit'(1) << ni;
            fs_n    = wrap;
        end
    end
endmodule

// File: tb/tb_static_to_dynamic_7seg_scanner.sv
// tb_static_to_dynamic_7seg_scanner: directed checks of scan order, snapshot isolation, enable drop and reset
module tb_static_to_dynamic_7seg_scanner;
`ifdef DYNAMIC_7SEG_BLANK_GAP_EN
    localparam int B = 2;
`else
    localparam int B = 0;
`endif
    localparam int P = 3 + B;
    localparam int F = 4 * P;
    localparam logic [3:0][7:0] ORIG = {8'h4F, 8'h5B, 8'h06, 8'h3F};
    localparam logic [3:0][7:0] MODI = {8'hFF, 8'h5B, 8'h06, 8'h3F};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b1;
    logic [3:0][7:0] hex = ORIG;
    logic [7:0] hgfedcba;
    logic [3:0] digit;
    logic frame_start;
    int n_cmp = 0;
    int n_bad = 0;

    static_to_dynamic_7seg_scanner #(
        .w_digit(4), .w_seg(8), .dwell_cycles(3), .blank_cycles(2)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .hex(hex),
        .hgfedcba(hgfedcba), .digit(digit), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ed, input logic [7:0] es, input logic ef);
        chk({tag, " digit"}, {4'b0, digit}, {4'b0, ed});
        chk({tag, " seg"}, hgfedcba, es);
        chk({tag, " frame_start"}, {7'b0, frame_start}, {7'b0, ef});
    endtask

    // Expected outputs for frame position p: first 3 cycles of each P-cycle slot drive the digit
    task automatic run(input int from, input int to, input logic [3:0][7:0] img);
        for (int p = from; p <= to; p++) begin
            int d;
            logic [3:0] ed;
            logic [7:0] es;
            tick();
            d  = p / P;
            ed = (p % P) < 3 ? 4'(1) << d : 4'b0;
            es = (p % P) < 3 ? img[d] : 8'h00;
            chk_all($sformatf("p%0d", p), ed, es, p == 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("reset%0d", i), 4'b0, 8'h00, 1'b0);
        end
        rst = 1'b1;
        run(0, F - 1, ORIG);
        run(0, P, ORIG);
        hex[3] = 8'hFF;
        run(P + 1, F - 1, ORIG);
        run(0, F - 1, MODI);
        run(0, 2 * P + 1, MODI);
        enable = 1'b0;
        tick();
        chk_all("endrop0", 4'b0, 8'h00, 1'b0);
        tick();
        chk_all("endrop1", 4'b0, 8'h00, 1'b0);
        enable = 1'b1;
        run(0, F - 1, MODI);
        run(0, P + 3, MODI);
        rst = 1'b0;
        tick();
        chk_all("midreset", 4'b0, 8'h00, 1'b0);
        rst = 1'b1;
        run(0, F - 1, MODI);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
